// File: rtl/electronic_voting_machine.sv
// Six-channel vote tally: five candidates plus NOTA, one saturating counter per channel.
// Optional build macro EVM_INPUT_SYNC_EN adds a two-flop synchronizer on each button.
module electronic_voting_machine #(
    parameter int CNT_W = 10
) (
    input  logic             CLK,
    input  logic             CLEAR,
    input  logic             P1,
    input  logic             P2,
    input  logic             P3,
    input  logic             P4,
    input  logic             P5,
    input  logic             NOTA,
    output logic [CNT_W-1:0] P1_VOTES,
    output logic [CNT_W-1:0] P2_VOTES,
    output logic [CNT_W-1:0] P3_VOTES,
    output logic [CNT_W-1:0] P4_VOTES,
    output logic [CNT_W-1:0] P5_VOTES,
    output logic [CNT_W-1:0] NOTA_VOTES
);

    localparam int NCH = 6;

    logic [NCH-1:0]   buttons;
    logic [NCH-1:0]   sampled;
    logic [NCH-1:0]   prev;
    logic [NCH-1:0]   rise;
    logic             accept;
    logic [CNT_W-1:0] tally [NCH];

    assign buttons = {NOTA, P5, P4, P3, P2, P1};

`ifdef EVM_INPUT_SYNC_EN
    logic [NCH-1:0] sync_1;
    logic [NCH-1:0] sync_2;

    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= buttons;
            sync_2 <= sync_1;
        end
    end

    assign sampled = sync_2;
`else
    assign sampled = buttons;
`endif

    // prev also loads during CLEAR, so a button held through CLEAR is not seen as a rise.
    always_ff @(posedge CLK) begin
        prev <= sampled;
    end

    // A vote is valid only when the single active button is also the one that just rose.
    always_comb begin
        rise   = sampled & ~prev;
        accept = $onehot(sampled) && (rise == sampled);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        always_ff @(posedge CLK) begin
            if (CLEAR) begin
                tally[i] <= '0;
            end else if (accept && rise[i] && (tally[i] != {CNT_W{1'b1}})) begin
                tally[i] <= tally[i] + 1'b1;
            end
        end
    end

    assign P1_VOTES   = tally[0];
    assign P2_VOTES   = tally[1];
    assign P3_VOTES   = tally[2];
    assign P4_VOTES   = tally[3];
    assign P5_VOTES   = tally[4];
    assign NOTA_VOTES = tally[5];

endmodule

// File: tb/tb_electronic_voting_machine.sv
// Table-driven bench for electronic_voting_machine (default build, no input synchronizer).
module tb_electronic_voting_machine;

   logic       CLK = 1'b0;
   logic       CLEAR = 1'b0;
   logic       P1 = 1'b0, P2 = 1'b0, P3 = 1'b0, P4 = 1'b0, P5 = 1'b0, NOTA = 1'b0;
   logic [9:0] P1_VOTES, P2_VOTES, P3_VOTES, P4_VOTES, P5_VOTES, NOTA_VOTES;

   electronic_voting_machine #(.CNT_W(10)) dut (
      .CLK       (CLK),
      .CLEAR     (CLEAR),
      .P1        (P1),
      .P2        (P2),
      .P3        (P3),
      .P4        (P4),
      .P5        (P5),
      .NOTA      (NOTA),
      .P1_VOTES  (P1_VOTES),
      .P2_VOTES  (P2_VOTES),
      .P3_VOTES  (P3_VOTES),
      .P4_VOTES  (P4_VOTES),
      .P5_VOTES  (P5_VOTES),
      .NOTA_VOTES(NOTA_VOTES)
   );

   always #5 CLK = ~CLK;

   // Button bit order: 0=P1 .. 4=P5, 5=NOTA. Tallies packed {NOTA,P5,P4,P3,P2,P1}.
   typedef struct {
      logic        clr;
      logic [5:0]  btn;
      bit          chk;
      logic [59:0] exp;
      string       name;
   } vec_t;

   vec_t        vecs[$];
   logic [59:0] sb[$];
   string       sb_name[$];
   int          tests = 0;
   int          fails = 0;

   function automatic logic [59:0] t(int a, int b, int c, int d, int e, int f);
      return {10'(f), 10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
   endfunction

   function automatic void step(logic clr, logic [5:0] btn, bit chk, logic [59:0] e, string n);
      vec_t v;
      v.clr = clr; v.btn = btn; v.chk = chk; v.exp = e; v.name = n;
      vecs.push_back(v);
   endfunction

   // One-cycle press then one-cycle release; tally must already show the vote after the press edge.
   function automatic void press(int ch, bit chk, logic [59:0] e, string n);
      step(1'b0, 6'(1 << ch), chk, e, n);
      step(1'b0, 6'b0, chk, e, n);
   endfunction

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: run exceeded time limit, got %0d checks, required completion", tests);
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [59:0] got, want;
      string       nm;

      step(1'b1, 6'b0, 1, t(0,0,0,0,0,0), "reset");
      press(0, 1, t(1,0,0,0,0,0), "first_p1");
      press(1, 1, t(1,1,0,0,0,0), "first_p2");
      press(2, 1, t(1,1,1,0,0,0), "first_p3");
      press(3, 1, t(1,1,1,1,0,0), "first_p4");
      press(4, 1, t(1,1,1,1,1,0), "first_p5");
      press(5, 1, t(1,1,1,1,1,1), "first_nota");
      press(0, 0, 0, ""); press(0, 1, t(3,1,1,1,1,1), "p1x2");
      press(2, 0, 0, ""); press(2, 0, 0, ""); press(2, 1, t(3,1,4,1,1,1), "p3x3");
      press(4, 1, t(3,1,4,1,2,1), "p5x1");
      press(1, 0, 0, ""); press(3, 0, 0, ""); press(5, 0, 0, "");
      press(0, 0, 0, ""); press(1, 0, 0, "");
      press(4, 1, t(4,3,4,2,3,2), "mixed_six");
      for (int i = 0; i < 8; i++) step(1'b0, 6'b000010, 1, t(4,4,4,2,3,2), "hold_p2");
      step(1'b0, 6'b0, 1, t(4,4,4,2,3,2), "hold_p2_release");
      step(1'b0, 6'b001001, 1, t(4,4,4,2,3,2), "p1_p4_same_cycle");
      step(1'b0, 6'b0, 1, t(4,4,4,2,3,2), "p1_p4_release");
      step(1'b0, 6'b010000, 1, t(4,4,4,2,4,2), "p5_alone");
      step(1'b0, 6'b010100, 1, t(4,4,4,2,4,2), "p3_while_p5_held");
      step(1'b0, 6'b010000, 1, t(4,4,4,2,4,2), "p5_still_held");
      step(1'b0, 6'b0, 1, t(4,4,4,2,4,2), "overlap_release");
      step(1'b1, 6'b0, 1, t(0,0,0,0,0,0), "mid_clear");
      press(2, 0, 0, ""); press(3, 0, 0, "");
      press(5, 1, t(0,0,1,1,0,1), "after_clear");
      step(1'b1, 6'b000010, 1, t(0,0,0,0,0,0), "clear_beats_vote");
      step(1'b0, 6'b000010, 1, t(0,0,0,0,0,0), "held_across_clear");
      step(1'b0, 6'b000010, 1, t(0,0,0,0,0,0), "held_across_clear2");
      step(1'b0, 6'b0, 1, t(0,0,0,0,0,0), "held_release");
      press(1, 1, t(0,1,0,0,0,0), "repress_after_clear");
      for (int n = 1; n <= 1030; n++) begin
         if (n >= 1021)
            press(4, 1, t(0,1,0,0,(n > 1023) ? 1023 : n,0), "saturate");
         else
            press(4, 0, 0, "");
      end

      CLEAR = 1'b0;
      foreach (vecs[k]) begin
         @(negedge CLK);
         CLEAR = vecs[k].clr;
         {NOTA, P5, P4, P3, P2, P1} = vecs[k].btn;
         if (vecs[k].chk) begin
            sb.push_back(vecs[k].exp);
            sb_name.push_back(vecs[k].name);
         end
         @(posedge CLK);
         #1;
         if (vecs[k].chk) begin
            want = sb.pop_front();
            nm   = sb_name.pop_front();
            got  = {NOTA_VOTES, P5_VOTES, P4_VOTES, P3_VOTES, P2_VOTES, P1_VOTES};
            tests++;
            if (got !== want) begin
               fails++;
               $display("FAIL %s (vec %0d): got P1..NOTA=%0d,%0d,%0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d,%0d,%0d",
                        nm, k, got[9:0], got[19:10], got[29:20], got[39:30], got[49:40], got[59:50],
                        want[9:0], want[19:10], want[29:20], want[39:30], want[49:40], want[59:50]);
            end
         end
      end

      @(negedge CLK);
      tests++;
      if (P1_VOTES !== 10'd0) begin
         fails++;
         $display("FAIL final_p1: got %0d required 0", P1_VOTES);
      end
      tests++;
      if (P2_VOTES !== 10'd1) begin
         fails++;
         $display("FAIL final_p2: got %0d required 1", P2_VOTES);
      end
      tests++;
      if (P3_VOTES !== 10'd0) begin
         fails++;
         $display("FAIL final_p3: got %0d required 0", P3_VOTES);
      end
      tests++;
      if (P4_VOTES !== 10'd0) begin
         fails++;
         $display("FAIL final_p4: got %0d required 0", P4_VOTES);
      end
      tests++;
      if (P5_VOTES !== 10'd1023) begin
         fails++;
         $display("FAIL final_p5_saturated: got %0d required 1023", P5_VOTES);
      end
      tests++;
      if (NOTA_VOTES !== 10'd0) begin
         fails++;
         $display("FAIL final_nota: got %0d required 0", NOTA_VOTES);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/electronic_voting_machine.md
Name: electronic_voting_machine

Overview:
Six-channel vote tally block for a basic electronic voting machine: five candidate buttons plus NOTA ("none of the above"). Each accepted button press increments that channel's 10-bit counter by one. Sits between the debounced front-panel button inputs and the result display/readout logic. Single clock domain; synchronous active-high clear.

Parameters:
CNT_W, 10, width of each vote counter. Ports below are sized with this value.

Ports:
CLK  input  1  system clock; all state updates on rising edge
CLEAR  input  1  synchronous active-high reset/clear of all tallies
P1  input  1  candidate 1 button, active-high
P2  input  1  candidate 2 button, active-high
P3  input  1  candidate 3 button, active-high
P4  input  1  candidate 4 button, active-high
P5  input  1  candidate 5 button, active-high
NOTA  input  1  NOTA button, active-high
P1_VOTES  output  10  candidate 1 tally
P2_VOTES  output  10  candidate 2 tally
P3_VOTES  output  10  candidate 3 tally
P4_VOTES  output  10  candidate 4 tally
P5_VOTES  output  10  candidate 5 tally
NOTA_VOTES  output  10  NOTA tally

Behaviour:
- Interface: one clock CLK; reset CLEAR is synchronous and active-high.
- CLEAR=1 at a rising edge:
  - all six tallies go to 0;
  - the previous-sample register for the six buttons loads the current button values. A button held through CLEAR deassertion is therefore not counted until it is released and pressed again.
  - CLEAR has priority over any vote in the same cycle.
- Edge detection: a registered copy of the six buttons (prev) is kept. A rise on channel i means button_i=1 and prev_i=0 at the sampling edge.
- Vote acceptance is evaluated at each rising edge with CLEAR=0:
  - exactly one channel rises, and all other five buttons are 0 → that channel's tally increments by 1;
  - otherwise (no rise, two or more rises, or a rise while any other button is held) → no tally changes. Such a simultaneous or overlapping press is discarded entirely.
- Holding a button for any number of cycles counts once. A new vote requires at least one cycle with the button low.
- Latency: the incremented tally is visible on the output immediately after the rising edge that sampled the press (1 cycle). A press held for exactly one cycle is counted.
- Saturation: a tally at 1023 stays at 1023 on further accepted votes (no wrap). Other channels are unaffected.
- Outputs are driven directly from registers; no combinational path from inputs to outputs.
- Before the first CLEAR, output values are undefined. Benches must apply CLEAR first.

Optional Feature:
Macro EVM_INPUT_SYNC_EN.
- Defined: each button passes through a two-flop synchronizer (reset to 0 by CLEAR) before edge detection. Vote latency becomes 3 cycles from the input change. A press must be held for at least 1 cycle, as before.
- Not defined: buttons feed edge detection directly, with 1-cycle latency as specified above.
- All other rules are identical in both builds.

Test Plan:
- CLEAR for 1 cycle, then one press each of P1,P2,P3,P4,P5,NOTA (each held 1 cycle, released 1 cycle) → all tallies =1.
- Then P1×2, P3×3, P5×1 → P1=3, P2=1, P3=4, P4=1, P5=2, NOTA=1. Then P2,P4,NOTA,P1,P2,P5 → P1=4, P2=3, P3=4, P4=2, P5=3, NOTA=2.
- Hold P2 high for 8 cycles, then release → P2 increments by exactly 1. Press P1 and P4 in the same cycle → no tally changes. Press P3 while P5 is held → no change.
- CLEAR for 1 cycle mid-session → all tallies 0 on the next edge. Then P3, P4, NOTA → P3=1, P4=1, NOTA=1, others 0. Button held across CLEAR deassertion → not counted.
- 1030 discrete presses on P5 → P5_VOTES=1023, saturated; other tallies unchanged.
- With EVM_INPUT_SYNC_EN defined, repeat the first scenario → same final values. First tally update appears 3 cycles after P1 rises.
